// File: rtl/calc_pkg.sv
// Shared constants and FSM state encoding for the calculator display path.
package calc_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] ERR_DIGIT = 4'hE;
  localparam int BCD_MAX = 999;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD nibble that is 5 or more.
module bcd_add3
  import calc_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle,
// with an E/E/E error pattern for values above 999.
module bcd_converter
  import calc_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   value,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic [DIGIT_W-1:0] hex0char,
  output logic [DIGIT_W-1:0] hex1char,
  output logic [DIGIT_W-1:0] hex2char,
  output state_t             dbg_state
);
  localparam int SCR_W = DIGITS * DIGIT_W;
  localparam int CNT_W = $clog2(WIDTH + 1);

  // Handshake: start is a request that is taken on any rising edge where the
  // converter is not busy (IDLE or DONE); while busy=1 start is ignored and
  // never queued. done pulses for one cycle when the digit outputs update.

  state_t             state_q;
  logic [WIDTH-1:0]   bin_q;
  logic [SCR_W-1:0]   scratch_q;
  logic [SCR_W-1:0]   scratch_adj;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_pend_q;
  logic               accept;
  logic [SCR_W+WIDTH-1:0] shifted;
  logic [SCR_W-1:0]   scratch_next;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (scratch_q[g*DIGIT_W +: DIGIT_W]),
      .dout (scratch_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign shifted      = {scratch_adj, bin_q} << 1;
  assign scratch_next = shifted[SCR_W+WIDTH-1:WIDTH];
  assign accept       = start && (state_q != S_SHIFT);
  assign dbg_state    = state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      bin_q      <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      hex0char   <= '0;
      hex1char   <= '0;
      hex2char   <= '0;
    end else begin
      case (state_q)
        S_SHIFT: begin
          scratch_q <= scratch_next;
          bin_q     <= shifted[WIDTH-1:0];
          cnt_q     <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            // Out-of-range values discard the scratch entirely.
            if (ovf_pend_q) begin
              hex0char <= ERR_DIGIT;
              hex1char <= ERR_DIGIT;
              hex2char <= ERR_DIGIT;
              overflow <= 1'b1;
            end else begin
              hex0char <= scratch_next[3:0];
              hex1char <= scratch_next[7:4];
              hex2char <= scratch_next[11:8];
              overflow <= 1'b0;
            end
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= S_DONE;
          end
        end
        default: begin
          done <= 1'b0;
          if (accept) begin
            bin_q      <= value;
            scratch_q  <= '0;
            cnt_q      <= CNT_W'(WIDTH);
            ovf_pend_q <= (32'(value) > BCD_MAX);
            busy       <= 1'b1;
            state_q    <= S_SHIFT;
          end else begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_converter.sv
// Directed self-checking bench for bcd_converter (WIDTH=10).
module tb_bcd_converter;
  import calc_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [9:0] value;
  logic       busy, done, overflow;
  logic [3:0] hex0char, hex1char, hex2char;
  state_t     dbg_state;

  int checks = 0;
  int failures = 0;

  bcd_converter #(.WIDTH(10), .DIGITS(3)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .value(value),
    .busy(busy), .done(done), .overflow(overflow),
    .hex0char(hex0char), .hex1char(hex1char), .hex2char(hex2char),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents value with start for one cycle; returns in cycle 1 of the conversion.
  task automatic start_conv(input logic [9:0] v);
    value = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    value = ~v;
  endtask

  // Steps until done is seen, bounded; n = cycles stepped.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    value   = '0;
    tick();
    tick();
    checks++;
    if ({busy, done, overflow, hex2char, hex1char, hex0char} !== 15'h0 || dbg_state !== S_IDLE) begin
      failures++;
      $display("FAIL reset_state: got busy=%b done=%b ovf=%b digits=%h%h%h required all zero",
               busy, done, overflow, hex2char, hex1char, hex0char);
    end
    reset_n = 1'b1;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_basic_timing();
    int bad = 0;
    start_conv(10'd371);
    for (int c = 1; c <= 10; c++) begin
      if (busy !== 1'b1 || done !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL busy_window: %0d of cycles 1..10 had busy!=1 or done!=0, required 0", bad);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0 ||
        {hex2char, hex1char, hex0char} !== 12'h371) begin
      failures++;
      $display("FAIL conv_371: cycle11 done=%b busy=%b ovf=%b digits=%h%h%h required done=1 busy=0 ovf=0 371",
               done, busy, overflow, hex2char, hex1char, hex0char);
    end
    tick();
    checks++;
    if (done !== 1'b0 || {hex2char, hex1char, hex0char} !== 12'h371) begin
      failures++;
      $display("FAIL done_width_371: cycle12 done=%b digits=%h%h%h required done=0 371",
               done, hex2char, hex1char, hex0char);
    end
  endtask

  task automatic test_values();
    logic [9:0]  vals [4] = '{10'd0, 10'd9, 10'd10, 10'd999};
    logic [11:0] exps [4] = '{12'h000, 12'h009, 12'h010, 12'h999};
    int n;
    for (int i = 0; i < 4; i++) begin
      start_conv(vals[i]);
      wait_done(n);
      checks++;
      if (n != 10 || {hex2char, hex1char, hex0char} !== exps[i] || overflow !== 1'b0) begin
        failures++;
        $display("FAIL value_%0d: done_cycle=%0d digits=%h%h%h ovf=%b required cycle 11 digits=%h ovf=0",
                 vals[i], n + 1, hex2char, hex1char, hex0char, overflow, exps[i]);
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
        failures++;
        $display("FAIL done_pulse_%0d: done=%b one cycle after pulse, required 0", vals[i], done);
      end
    end
  endtask

  task automatic test_overflow();
    logic [9:0] vals [2] = '{10'd1000, 10'd1023};
    int n;
    for (int i = 0; i < 2; i++) begin
      start_conv(vals[i]);
      wait_done(n);
      checks++;
      if (n != 10 || overflow !== 1'b1 || {hex2char, hex1char, hex0char} !== 12'hEEE) begin
        failures++;
        $display("FAIL overflow_%0d: done_cycle=%0d ovf=%b digits=%h%h%h required cycle 11 ovf=1 EEE",
                 vals[i], n + 1, overflow, hex2char, hex1char, hex0char);
      end
      tick();
      checks++;
      if (overflow !== 1'b1 || {hex2char, hex1char, hex0char} !== 12'hEEE) begin
        failures++;
        $display("FAIL overflow_hold_%0d: ovf=%b digits=%h%h%h required 1 EEE",
                 vals[i], overflow, hex2char, hex1char, hex0char);
      end
    end
    start_conv(10'd42);
    wait_done(n);
    checks++;
    if (n != 10 || overflow !== 1'b0 || {hex2char, hex1char, hex0char} !== 12'h042) begin
      failures++;
      $display("FAIL after_overflow_42: done_cycle=%0d ovf=%b digits=%h%h%h required cycle 11 ovf=0 042",
               n + 1, overflow, hex2char, hex1char, hex0char);
    end
    tick();
  endtask

  task automatic test_start_while_busy();
    int n;
    int extra = 0;
    start_conv(10'd123);
    tick();
    tick();
    tick();
    value = 10'd555;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    checks++;
    if (n != 6 || {hex2char, hex1char, hex0char} !== 12'h123) begin
      failures++;
      $display("FAIL busy_ignore_123: done_cycle=%0d digits=%h%h%h required cycle 11 digits 123",
               n + 5, hex2char, hex1char, hex0char);
    end
    for (int c = 0; c < 15; c++) begin
      tick();
      if (done === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL busy_ignore_no_second_done: got %0d done pulses required 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    start_conv(10'd64);
    wait_done(n);
    checks++;
    if (n != 10 || {hex2char, hex1char, hex0char} !== 12'h064) begin
      failures++;
      $display("FAIL b2b_first_64: done_cycle=%0d digits=%h%h%h required cycle 11 064",
               n + 1, hex2char, hex1char, hex0char);
    end
    value = 10'd808;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_accept: busy=%b done=%b after DONE-cycle start, required 1 0", busy, done);
    end
    wait_done(n);
    checks++;
    if (n != 10 || {hex2char, hex1char, hex0char} !== 12'h808 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second_808: gap=%0d digits=%h%h%h ovf=%b required gap 11 808 ovf=0",
               n + 1, hex2char, hex1char, hex0char, overflow);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int extra = 0;
    start_conv(10'd371);
    tick();
    tick();
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0 ||
        {hex2char, hex1char, hex0char} !== 12'h000 || dbg_state !== S_IDLE) begin
      failures++;
      $display("FAIL mid_reset: busy=%b done=%b ovf=%b digits=%h%h%h required 0 0 0 000",
               busy, done, overflow, hex2char, hex1char, hex0char);
    end
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL mid_reset_quiet: %0d cycles with busy/done after release, required 0", extra);
    end
  endtask

  initial begin
    test_reset();
    test_basic_timing();
    test_values();
    test_overflow();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
